bsg_fakeram_rw_adapter: RTL and testbench
=========================================

# bsg_fakeram_rw_adapter

Request-side controller for the 64x15 single-port fake SRAM macro. It accepts read and write requests on a valid/ready interface and drives the macro's ce/we/addr/wd/w_mask pins. It captures the macro's one-cycle-late read data into a 3-entry in-order response buffer, presented on a valid/yumi interface. After reset, the block can optionally zero the whole array, so the macro never holds X contents visible to the core.

## Interface
- width_p, 15, data/mask width; matches macro BITS
- els_p, 64, number of words; matches macro WORD_DEPTH
- addr_width_p, 6, address width, equal to $clog2(els_p)
- init_zero_p, 1, when 1, write zero to every word after reset before accepting requests
- clk_i  in  1  clock; everything is on the rising edge
- reset_i  in  1  synchronous, active-high reset
- v_i  in  1  request valid
- w_i  in  1  1 = write, 0 = read
- addr_i  in  addr_width_p  request address
- data_i  in  width_p  write data
- w_mask_i  in  width_p  per-bit write mask (1 = write the bit)
- ready_o  out  1  request accepted when v_i & ready_o
- v_o  out  1  read response valid
- data_o  out  width_p  read response data (head of buffer)
- yumi_i  in  1  consumer takes the response; legal only when v_o=1
- mem_ce_o, mem_we_o  out  1 each  macro ce_in / we_in
- mem_addr_o  out  addr_width_p  macro addr_in
- mem_wd_o, mem_w_mask_o  out  width_p each  macro wd_in / w_mask_in
- mem_rd_i  in  width_p  macro rd_out

## Operation
- FSM states: INIT and RUN.
  - Reset enters INIT if init_zero_p=1, otherwise RUN.
  - INIT → RUN after the cycle in which the init counter equals els_p-1.
- INIT behaviour:
  - The counter runs 0..els_p-1, one word per cycle.
  - Pins: mem_ce_o=1, mem_we_o=1, mem_addr_o=counter, mem_wd_o=0, mem_w_mask_o=all ones.
  - ready_o=0.
- RUN, ready_o: high when (buffer count + read_pending) < 3.
  - Registered terms only; no combinational path from v_i, w_i or yumi_i.
  - Applies to reads and writes alike.
- Macro pins in RUN:
  - When a request is accepted: mem_ce_o=1, mem_we_o=w_i, and addr/wd/mask pass through combinationally.
  - Otherwise mem_ce_o=0 and all other pins are driven 0, so X on the request bus never reaches the macro.
- Accepted read:
  - read_pending is set for the next cycle.
  - In that cycle mem_rd_i is pushed into the buffer tail.
- Accepted write: produces no response and does not touch the buffer.
- Buffer: 3 entries, FIFO order; a push and a pop may occur in the same cycle.
- Response outputs:
  - v_o = (count != 0).
  - data_o = head entry; it is 0 when the buffer is empty.
- yumi_i pops the head. yumi_i while v_o=0 is illegal; the bench flags it.
- Reset mid-operation:
  - Buffer, count and read_pending clear.
  - Any in-flight read is dropped.
  - The FSM re-enters INIT and the array is re-zeroed.

## Timing
- Reset values (the cycle reset_i is high and the first cycle after it):
  - ready_o=0, v_o=0, data_o=0.
  - mem_ce_o=0 during the reset cycle; all other mem pins 0.
- With init_zero_p=1:
  - The first ready_o=1 is cycle els_p+1 after reset deasserts (cycle 1 = first INIT cycle).
  - With init_zero_p=0, the first ready_o=1 is cycle 1.
- Read latency: accept in cycle t → v_o=1 and data_o valid in cycle t+2.
- Throughput:
  - One request per cycle, sustained indefinitely, when yumi_i is asserted every cycle v_o=1.
  - If the consumer stalls, at most 3 reads are outstanding (buffered plus pending), after which ready_o drops.
- Hazards:
  - A write in cycle t followed by a read of the same address in t+1 returns the new data (macro write-then-read order).
  - The adapter adds no forwarding.
- Requests are single-cycle to the macro; there is never more than one macro access per cycle.

## Test plan
- **Init sweep.** Stimulus: reset with init_zero_p=1, then 64 reads of addresses 0..63. Required: ready_o first goes high in cycle 65, and every read returns 0x0000.
- **Masked write.** Stimulus: write addr 5 data 0x7FFF mask 0x00FF, then write addr 5 data 0x0000 mask 0x000F, then read addr 5. Required: the read returns 0x00F0 exactly 2 cycles after accept.
- **Back-to-back streaming.** Stimulus: 64 consecutive reads with yumi_i tied to v_o. Required: ready_o stays high throughout and responses arrive in address order with no bubbles.
- **Backpressure.** Stimulus: yumi_i held 0, then read addrs 1,2,3,4 offered each cycle. Required: 3 are accepted, and ready_o=0 from the cycle after the third accept. Releasing yumi_i returns data for 1,2,3 in order, and addr 4 is then accepted.
- **Reset mid-stream.** Stimulus: 2 reads outstanding, then reset_i asserted for 1 cycle. Required: v_o=0 next cycle, no stale response ever appears, INIT re-runs, and a read of a previously written address returns 0.
- **X isolation.** Stimulus: X driven on addr_i/data_i/w_i while v_i=0 for 10 cycles, then a read of addr 7 previously written with 0x1234. Required: mem_ce_o=0 and the mem pins are 0 during the X cycles, and the read returns 0x1234.

Source files
------------

// File: rtl/bsg_fakeram_rw_adapter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : bsg_fakeram_rw_adapter_if                                      |
// | Purpose  : Request/response and macro-pin bundle for the fake SRAM        |
// |            read/write adapter.                                            |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
interface bsg_fakeram_rw_adapter_if #(
  parameter int width_p      = 15,
  parameter int addr_width_p = 6
);
  logic                    v_i;
  logic                    w_i;
  logic [addr_width_p-1:0] addr_i;
  logic [width_p-1:0]      data_i;
  logic [width_p-1:0]      w_mask_i;
  logic                    ready_o;
  logic                    v_o;
  logic [width_p-1:0]      data_o;
  logic                    yumi_i;
  logic                    mem_ce_o;
  logic                    mem_we_o;
  logic [addr_width_p-1:0] mem_addr_o;
  logic [width_p-1:0]      mem_wd_o;
  logic [width_p-1:0]      mem_w_mask_o;
  logic [width_p-1:0]      mem_rd_i;

  // Core side (and macro read-data return)
  modport master (
    output v_i, w_i, addr_i, data_i, w_mask_i, yumi_i, mem_rd_i,
    input  ready_o, v_o, data_o,
    input  mem_ce_o, mem_we_o, mem_addr_o, mem_wd_o, mem_w_mask_o
  );

  // Adapter side
  modport slave (
    input  v_i, w_i, addr_i, data_i, w_mask_i, yumi_i, mem_rd_i,
    output ready_o, v_o, data_o,
    output mem_ce_o, mem_we_o, mem_addr_o, mem_wd_o, mem_w_mask_o
  );
endinterface
`default_nettype wire

// File: rtl/bsg_fakeram_rw_adapter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : bsg_fakeram_rw_adapter                                         |
// | Purpose  : Drives a single-port fake SRAM macro from a valid/ready        |
// |            request port; buffers read data on a valid/yumi port.          |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
module bsg_fakeram_rw_adapter #(
  parameter int width_p      = 15,
  parameter int els_p        = 64,
  parameter int addr_width_p = 6,
  parameter int init_zero_p  = 1
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  bsg_fakeram_rw_adapter_if.slave   bus
);

  localparam int c_buf_els = 3;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e                  r_state;
  state_e                  w_state_next;
  logic [addr_width_p-1:0] r_init_cnt;
  logic [width_p-1:0]      r_buf [c_buf_els];
  logic [1:0]              r_head;
  logic [1:0]              r_tail;
  logic [1:0]              r_count;
  logic                    r_read_pending;

  logic                    w_ready;
  logic                    w_accept;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_init_last;
  logic [2:0]              w_occupancy;

  function automatic logic [1:0] f_next_ptr(input logic [1:0] p);
    return (p == 2'(c_buf_els - 1)) ? 2'd0 : p + 2'd1;
  endfunction

  // Pending read counts against capacity so its data always has a slot.
  assign w_occupancy = {1'b0, r_count} + {2'b00, r_read_pending};
  assign w_init_last = (r_init_cnt == addr_width_p'(els_p - 1));

  always_comb begin
    w_state_next = r_state;
    w_ready      = 1'b0;
    case (r_state)
      ST_INIT: begin
        if (w_init_last) w_state_next = ST_RUN;
      end
      ST_RUN: begin
        w_ready = (w_occupancy < 3'd3);
      end
      default: w_state_next = ST_RUN;
    endcase
    if (reset_i) w_ready = 1'b0;
  end

  assign w_accept = bus.v_i & w_ready;
  assign w_push   = r_read_pending;
  assign w_pop    = bus.yumi_i & (r_count != 2'd0);

  // Idle pins are forced to zero so request-bus X never reaches the macro.
  always_comb begin
    bus.mem_ce_o     = 1'b0;
    bus.mem_we_o     = 1'b0;
    bus.mem_addr_o   = '0;
    bus.mem_wd_o     = '0;
    bus.mem_w_mask_o = '0;
    if (!reset_i && r_state == ST_INIT) begin
      bus.mem_ce_o     = 1'b1;
      bus.mem_we_o     = 1'b1;
      bus.mem_addr_o   = r_init_cnt;
      bus.mem_w_mask_o = '1;
    end else if (w_accept) begin
      bus.mem_ce_o     = 1'b1;
      bus.mem_we_o     = bus.w_i;
      bus.mem_addr_o   = bus.addr_i;
      bus.mem_wd_o     = bus.data_i;
      bus.mem_w_mask_o = bus.w_mask_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state        <= (init_zero_p != 0) ? ST_INIT : ST_RUN;
      r_init_cnt     <= '0;
      r_read_pending <= 1'b0;
      r_head         <= 2'd0;
      r_tail         <= 2'd0;
      r_count        <= 2'd0;
    end else begin
      r_state        <= w_state_next;
      r_read_pending <= w_accept & ~bus.w_i;
      if (r_state == ST_INIT)
        r_init_cnt <= w_init_last ? '0 : r_init_cnt + 1'b1;
      if (w_push) r_tail <= f_next_ptr(r_tail);
      if (w_pop)  r_head <= f_next_ptr(r_head);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset; data_o is masked while the buffer is empty.
  always_ff @(posedge clk_i) begin
    if (!reset_i && w_push) r_buf[r_tail] <= bus.mem_rd_i;
  end

  assign bus.ready_o = w_ready;
  assign bus.v_o     = (r_count != 2'd0);
  assign bus.data_o  = (r_count != 2'd0) ? r_buf[r_head] : '0;

endmodule
`default_nettype wire

// File: tb/tb_bsg_fakeram_rw_adapter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_bsg_fakeram_rw_adapter                                      |
// | Purpose  : Directed self-checking bench with a behavioural 64x15 macro.   |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_bsg_fakeram_rw_adapter;

  logic clk;
  logic reset;
  int   n_total;
  int   n_pass;
  logic v_at_neg;

  bsg_fakeram_rw_adapter_if #(.width_p(15), .addr_width_p(6)) bus ();

  bsg_fakeram_rw_adapter #(
    .width_p(15), .els_p(64), .addr_width_p(6), .init_zero_p(1)
  ) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Macro model: masked write, registered read, preloaded with garbage.
  logic [14:0] mem [64];
  bit          mem_filled;
  always @(posedge clk) begin
    if (!mem_filled) begin
      for (int i = 0; i < 64; i++) mem[i] <= 15'h5A5A;
      mem_filled <= 1'b1;
    end else if (bus.mem_ce_o === 1'b1) begin
      if (bus.mem_we_o === 1'b1)
        mem[bus.mem_addr_o] <= (mem[bus.mem_addr_o] & ~bus.mem_w_mask_o) |
                               (bus.mem_wd_o & bus.mem_w_mask_o);
      else
        bus.mem_rd_i <= mem[bus.mem_addr_o];
    end
  end

  // yumi_i is only legal while v_o is high.
  always @(negedge clk) v_at_neg = bus.v_o;
  always @(posedge clk) begin
    if (reset === 1'b0 && bus.yumi_i === 1'b1) begin
      n_total++;
      if (v_at_neg !== 1'b1) $display("FAIL yumi_legal: yumi_i=1 with v_o=%b, required v_o=1", v_at_neg);
      else n_pass++;
    end
  end

  function automatic logic [14:0] f_pat(input int a);
    return 15'((a * 37 + 'h155) & 'h7FFF);
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_ready(output bit ok);
    int n = 0;
    @(negedge clk);
    while (bus.ready_o !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    ok = (bus.ready_o === 1'b1);
  endtask

  task automatic do_write(input int a, input logic [14:0] d, input logic [14:0] m, output bit ok);
    bus.v_i = 1'b1; bus.w_i = 1'b1; bus.addr_i = 6'(a); bus.data_i = d; bus.w_mask_i = m;
    wait_ready(ok);
    tick();
    bus.v_i = 1'b0; bus.w_i = 1'b0;
  endtask

  task automatic do_read(input int a, output logic [14:0] d, output int lat, output bit ok);
    bus.v_i = 1'b1; bus.w_i = 1'b0; bus.addr_i = 6'(a);
    wait_ready(ok);
    tick();
    bus.v_i = 1'b0;
    lat = 1;
    @(negedge clk);
    while (bus.v_o !== 1'b1 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    d = bus.data_o;
    if (bus.v_o === 1'b1) begin
      bus.yumi_i = 1'b1;
      tick();
      bus.yumi_i = 1'b0;
    end else begin
      ok = 1'b0;
      tick();
    end
  endtask

  task automatic test_reset();
    int cyc;
    reset = 1'b1; bus.v_i = 1'b0; bus.w_i = 1'b0; bus.yumi_i = 1'b0;
    bus.addr_i = '0; bus.data_i = '0; bus.w_mask_i = '0;
    tick(); tick();
    @(negedge clk);
    n_total++;
    if ({bus.ready_o, bus.v_o, bus.data_o} !== 17'd0)
      $display("FAIL reset_outputs: ready/v/data=%b/%b/%h, required 0/0/0", bus.ready_o, bus.v_o, bus.data_o);
    else n_pass++;
    n_total++;
    if ({bus.mem_ce_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_wd_o, bus.mem_w_mask_o} !== 38'd0)
      $display("FAIL reset_pins: ce=%b addr=%h mask=%h, required all 0", bus.mem_ce_o, bus.mem_addr_o, bus.mem_w_mask_o);
    else n_pass++;
    tick();
    reset = 1'b0;
    @(negedge clk);
    n_total++;
    if (bus.mem_ce_o !== 1'b1 || bus.mem_we_o !== 1'b1 || bus.mem_addr_o !== 6'd0 ||
        bus.mem_wd_o !== 15'd0 || bus.mem_w_mask_o !== 15'h7FFF || bus.ready_o !== 1'b0 || bus.v_o !== 1'b0)
      $display("FAIL init_pins: ce=%b we=%b addr=%h wd=%h mask=%h ready=%b, required 1 1 00 0000 7fff 0",
               bus.mem_ce_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_wd_o, bus.mem_w_mask_o, bus.ready_o);
    else n_pass++;
    cyc = 1;
    while (bus.ready_o !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    n_total++;
    if (cyc != 65) $display("FAIL init_ready_cycle: first ready in cycle %0d, required 65", cyc);
    else n_pass++;
    tick();
  endtask

  task automatic test_init_sweep();
    logic [14:0] d; int lat; bit ok;
    for (int a = 0; a < 64; a++) begin
      do_read(a, d, lat, ok);
      n_total++;
      if (!ok || d !== 15'd0) $display("FAIL init_sweep: addr %0d read %h ok=%0d, required 0000", a, d, ok);
      else n_pass++;
    end
  endtask

  task automatic test_masked_write();
    logic [14:0] d; int lat; bit ok1, ok2, ok3;
    do_write(5, 15'h7FFF, 15'h00FF, ok1);
    do_write(5, 15'h0000, 15'h000F, ok2);
    do_read(5, d, lat, ok3);
    n_total++;
    if (!(ok1 && ok2 && ok3) || d !== 15'h00F0) $display("FAIL masked_write: read %h, required 00f0", d);
    else n_pass++;
    n_total++;
    if (lat != 2) $display("FAIL read_latency: latency %0d, required 2", lat);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int rdy_bad = 0;
    for (int a = 0; a < 64; a++) begin
      bus.v_i = 1'b1; bus.w_i = 1'b1; bus.addr_i = 6'(a); bus.data_i = f_pat(a); bus.w_mask_i = 15'h7FFF;
      @(negedge clk);
      if (bus.ready_o !== 1'b1) rdy_bad++;
      tick();
    end
    for (int c = 0; c < 66; c++) begin
      if (c < 64) begin
        bus.v_i = 1'b1; bus.w_i = 1'b0; bus.addr_i = 6'(c);
      end else bus.v_i = 1'b0;
      @(negedge clk);
      if (c < 64 && bus.ready_o !== 1'b1) rdy_bad++;
      if (c >= 2) begin
        n_total++;
        if (bus.v_o !== 1'b1 || bus.data_o !== f_pat(c - 2))
          $display("FAIL stream_resp: cycle %0d v=%b data=%h, required 1/%h", c, bus.v_o, bus.data_o, f_pat(c - 2));
        else n_pass++;
      end
      bus.yumi_i = bus.v_o;
      tick();
    end
    bus.yumi_i = 1'b0;
    n_total++;
    if (rdy_bad != 0) $display("FAIL stream_ready: ready low in %0d cycles, required 0", rdy_bad);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    logic       rdy [5];
    logic [4:0] rdy_vec;
    int         cur = 1;
    logic [14:0] d; int lat; bit ok;
    bus.yumi_i = 1'b0;
    for (int c = 0; c < 5; c++) begin
      bus.v_i = 1'b1; bus.w_i = 1'b0; bus.addr_i = 6'(cur);
      @(negedge clk);
      rdy[c] = bus.ready_o;
      tick();
      if (rdy[c] === 1'b1) cur++;
    end
    bus.v_i = 1'b0;
    rdy_vec = {rdy[0], rdy[1], rdy[2], rdy[3], rdy[4]};
    n_total++;
    if (rdy_vec !== 5'b11100) $display("FAIL bp_ready: ready pattern %b, required 11100", rdy_vec);
    else n_pass++;
    n_total++;
    if (cur != 4) $display("FAIL bp_accepts: next addr %0d, required 4", cur);
    else n_pass++;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      n_total++;
      if (bus.v_o !== 1'b1 || bus.data_o !== f_pat(k))
        $display("FAIL bp_drain: entry %0d v=%b data=%h, required 1/%h", k, bus.v_o, bus.data_o, f_pat(k));
      else n_pass++;
      bus.yumi_i = 1'b1;
      tick();
      bus.yumi_i = 1'b0;
    end
    do_read(4, d, lat, ok);
    n_total++;
    if (!ok || d !== f_pat(4) || lat != 2) $display("FAIL bp_addr4: read %h lat %0d, required %h lat 2", d, lat, f_pat(4));
    else n_pass++;
  endtask

  task automatic test_hazard();
    bit rdy_ok;
    bus.v_i = 1'b1; bus.w_i = 1'b1; bus.addr_i = 6'd9; bus.data_i = 15'h0ABC; bus.w_mask_i = 15'h7FFF;
    @(negedge clk);
    rdy_ok = (bus.ready_o === 1'b1);
    tick();
    bus.w_i = 1'b0;
    @(negedge clk);
    rdy_ok = rdy_ok && (bus.ready_o === 1'b1);
    tick();
    bus.v_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_total++;
    if (!rdy_ok || bus.v_o !== 1'b1 || bus.data_o !== 15'h0ABC)
      $display("FAIL write_then_read: v=%b data=%h, required 1/0abc", bus.v_o, bus.data_o);
    else n_pass++;
    bus.yumi_i = 1'b1;
    tick();
    bus.yumi_i = 1'b0;
  endtask

  task automatic test_x_isolation();
    logic [14:0] d; int lat; bit ok, okw;
    do_write(7, 15'h1234, 15'h7FFF, okw);
    bus.v_i = 1'b0; bus.w_i = 1'bx; bus.addr_i = 'x; bus.data_i = 'x; bus.w_mask_i = 'x;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_total++;
      if ({bus.mem_ce_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_wd_o, bus.mem_w_mask_o} !== 38'd0)
        $display("FAIL x_isolation: cycle %0d ce=%b we=%b addr=%h wd=%h mask=%h, required all 0",
                 c, bus.mem_ce_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_wd_o, bus.mem_w_mask_o);
      else n_pass++;
      tick();
    end
    bus.data_i = '0; bus.w_mask_i = '0;
    do_read(7, d, lat, ok);
    n_total++;
    if (!(ok && okw) || d !== 15'h1234) $display("FAIL x_read7: read %h, required 1234", d);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [14:0] d; int lat; bit ok, okw; int cyc; int stale = 0;
    do_write(20, 15'h2AAA, 15'h7FFF, okw);
    bus.yumi_i = 1'b0;
    bus.v_i = 1'b1; bus.w_i = 1'b0; bus.addr_i = 6'd20;
    tick();
    bus.addr_i = 6'd21;
    tick();
    bus.v_i = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    n_total++;
    if (bus.v_o !== 1'b0) $display("FAIL reset_mid_v: v_o=%b after reset, required 0", bus.v_o);
    else n_pass++;
    cyc = 1;
    while (bus.ready_o !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      if (bus.v_o !== 1'b0) stale++;
      cyc++;
    end
    n_total++;
    if (cyc != 65 || stale != 0) $display("FAIL reset_mid_init: ready cycle %0d stale %0d, required 65/0", cyc, stale);
    else n_pass++;
    tick();
    do_read(20, d, lat, ok);
    n_total++;
    if (!(ok && okw) || d !== 15'd0) $display("FAIL reset_mid_rezero: read %h, required 0000", d);
    else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    n_total = 0;
    n_pass  = 0;
    test_reset();
    test_init_sweep();
    test_masked_write();
    test_back_to_back();
    test_backpressure();
    test_hazard();
    test_x_isolation();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
